// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive path.
package rgmii_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } rx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         FRAME_LEN_W   = 16;

  // Rebuild one byte from the two nibbles captured on either clock edge.
  function automatic logic [7:0] ddr_byte(input logic [4:0] rise, input logic [4:0] fall);
    return {fall[3:0], rise[3:0]};
  endfunction

endpackage

// File: rtl/rgmii_rx_stats.sv
// Receive statistics: delivered frame count and bad/dropped frame count.
module rgmii_rx_stats
  import rgmii_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   last,
  input  logic                   error,
  input  logic                   drop,
  output logic [FRAME_LEN_W-1:0] stat_frames,
  output logic [FRAME_LEN_W-1:0] stat_errors
);

  // Free-running wrapping counters; a bad delivered frame and a dropped frame each count once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_errors <= '0;
    end else begin
      if (last) begin
        stat_frames <= stat_frames + 1'b1;
      end
      stat_errors <= stat_errors + FRAME_LEN_W'(last & error) + FRAME_LEN_W'(drop);
    end
  end

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: rebuilds bytes from DDR nibble pairs, strips preamble/SFD,
// streams payload with end-of-frame/error flags, frame length and statistics.
module rgmii_rx_framer
  import rgmii_pkg::*;
#(
  parameter int MIN_PREAMBLE = 1,
  parameter int MIN_LEN      = 64,
  parameter int MAX_LEN      = 1518
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             ddr_rise,
  input  logic [4:0]             ddr_fall,
  output logic [7:0]             m_data,
  output logic                   m_valid,
  output logic                   m_last,
  output logic                   m_error,
  output logic [FRAME_LEN_W-1:0] frame_len,
  output logic [FRAME_LEN_W-1:0] stat_frames,
  output logic [FRAME_LEN_W-1:0] stat_errors
);

  rx_state_t              state;
  logic [7:0]             rx_byte;
  logic                   dv;
  logic                   er;
  logic [2:0]             pcnt;
  logic [FRAME_LEN_W-1:0] len;
  logic                   err;
  logic [7:0]             hold_data;
  logic                   hold_full;
  logic                   drop_pulse;
  logic                   frame_bad;

  // Per-cycle decode of the DDR pair into byte, data-valid and receive-error.
  always_comb begin
    rx_byte   = ddr_byte(ddr_rise, ddr_fall);
    dv        = ddr_rise[4];
    er        = ddr_rise[4] ^ ddr_fall[4];
    frame_bad = err | (int'(len) < MIN_LEN) | (int'(len) > MAX_LEN);
  end

  // Framer FSM; the one-byte hold register lets the final byte carry m_last
  // when dv drops, so mid and last bytes share the same two-cycle latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pcnt       <= '0;
      len        <= '0;
      err        <= 1'b0;
      hold_data  <= '0;
      hold_full  <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_error    <= 1'b0;
      frame_len  <= '0;
      drop_pulse <= 1'b0;
    end else begin
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      m_error    <= 1'b0;
      frame_len  <= '0;
      drop_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (dv) begin
            if (rx_byte == PREAMBLE_BYTE && !er) begin
              state <= PRE;
              pcnt  <= 3'd1;
            end else begin
              state <= DROP;
            end
          end
        end
        PRE: begin
          if (!dv) begin
            state      <= IDLE;
            drop_pulse <= 1'b1;
          end else if (er) begin
            state <= DROP;
          end else if (rx_byte == PREAMBLE_BYTE) begin
            if (pcnt != 3'd7) begin
              pcnt <= pcnt + 3'd1;
            end
          end else if (rx_byte == SFD_BYTE && int'(pcnt) >= MIN_PREAMBLE) begin
            state     <= DATA;
            len       <= '0;
            err       <= 1'b0;
            hold_full <= 1'b0;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (dv) begin
            hold_data <= rx_byte;
            hold_full <= 1'b1;
            if (len != '1) begin
              len <= len + 1'b1;
            end
            if (er) begin
              err <= 1'b1;
            end
            if (hold_full) begin
              m_data  <= hold_data;
              m_valid <= 1'b1;
            end
          end else begin
            state     <= IDLE;
            hold_full <= 1'b0;
            if (hold_full) begin
              m_data    <= hold_data;
              m_valid   <= 1'b1;
              m_last    <= 1'b1;
              m_error   <= frame_bad;
              frame_len <= len;
            end else begin
              drop_pulse <= 1'b1;
            end
          end
        end
        DROP: begin
          if (!dv) begin
            state      <= IDLE;
            drop_pulse <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rgmii_rx_stats u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .last        (m_valid & m_last),
    .error       (m_error),
    .drop        (drop_pulse),
    .stat_frames (stat_frames),
    .stat_errors (stat_errors)
  );

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Self-checking bench for rgmii_rx_framer: bursts of RGMII symbols are driven
// one per clock, every delivered beat is logged, and the log is compared with a
// frame-level reference model (expected bytes, flags, length, arrival cycle).
module tb_rgmii_rx_framer;

  localparam int MIN_PREAMBLE = 1;
  localparam int MIN_LEN      = 64;
  localparam int MAX_LEN      = 1518;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ddr_rise;
  logic [4:0]  ddr_fall;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_error;
  logic [15:0] frame_len;
  logic [15:0] stat_frames;
  logic [15:0] stat_errors;

  typedef struct packed {
    logic [7:0]  data;
    logic        last;
    logic        error;
    logic [15:0] len;
    int unsigned cyc;
  } beat_t;

  typedef struct packed {
    logic       er;
    logic [7:0] b;
  } sym_t;

  beat_t       obs[$];
  beat_t       exp_q[$];
  sym_t        burst[$];
  int unsigned cyc;
  int          n_cmp;
  int          n_bad;
  int          exp_frames;
  int          exp_errors;

  always #5 clk = ~clk;

  rgmii_rx_framer #(
    .MIN_PREAMBLE (MIN_PREAMBLE),
    .MIN_LEN      (MIN_LEN),
    .MAX_LEN      (MAX_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ddr_rise    (ddr_rise),
    .ddr_fall    (ddr_fall),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_last      (m_last),
    .m_error     (m_error),
    .frame_len   (frame_len),
    .stat_frames (stat_frames),
    .stat_errors (stat_errors)
  );

  // One symbol per clock: drive after the falling edge, sample at the next falling edge.
  task automatic step(input logic dv, input logic er, input logic [7:0] b);
    ddr_rise = {dv, b[3:0]};
    ddr_fall = {dv ^ er, b[7:4]};
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (m_valid === 1'b1)
      obs.push_back('{data: m_data, last: m_last, error: m_last ? m_error : 1'b0,
                      len: m_last ? frame_len : 16'd0, cyc: cyc});
  endtask

  // dv=0 cycle with arbitrary in-band status content.
  task automatic step_idle();
    step(1'b0, 1'($urandom), 8'($urandom));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step_idle();
    rst_n = 1'b1;
    step_idle();
    obs.delete();
    exp_q.delete();
    exp_frames = 0;
    exp_errors = 0;
  endtask

  task automatic build(input int pre, input int plen, input bit seq);
    burst.delete();
    repeat (pre) burst.push_back('{er: 1'b0, b: 8'h55});
    burst.push_back('{er: 1'b0, b: 8'hD5});
    for (int i = 0; i < plen; i++)
      burst.push_back('{er: 1'b0, b: seq ? 8'(i) : 8'($urandom)});
  endtask

  // Frame-level reference: a burst is a frame only if it opens with enough clean
  // 0x55 bytes followed by a clean 0xD5 and at least one payload byte; anything
  // else counts as one dropped frame. Each payload byte arrives 2 cycles after it is driven.
  task automatic model_burst(input int unsigned start);
    int  n;
    int  k;
    int  plen;
    bit  anyer;
    bit  bad;
    n = burst.size();
    k = 0;
    while (k < n && burst[k].b == 8'h55 && !burst[k].er) k++;
    if (k < MIN_PREAMBLE || k >= n || burst[k].b != 8'hD5 || burst[k].er || k + 1 == n) begin
      exp_errors++;
      return;
    end
    plen  = n - k - 1;
    anyer = 1'b0;
    for (int j = k + 1; j < n; j++) anyer |= burst[j].er;
    bad = anyer || plen < MIN_LEN || plen > MAX_LEN;
    for (int j = k + 1; j < n; j++) begin
      exp_q.push_back('{data: burst[j].b, last: (j == n - 1), error: (j == n - 1) ? bad : 1'b0,
                        len: (j == n - 1) ? ((plen > 65535) ? 16'hFFFF : 16'(plen)) : 16'd0,
                        cyc: start + 32'(j) + 2});
    end
    exp_frames++;
    if (bad) exp_errors++;
  endtask

  task automatic run_burst(input int gap);
    int unsigned start;
    start = cyc;
    model_burst(start);
    foreach (burst[i]) step(1'b1, burst[i].er, burst[i].b);
    repeat (gap) step_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step_idle();
    step_idle();
    n_cmp++;
    if ({m_valid, m_last, m_error} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got v/l/e=%b%b%b expected 000", m_valid, m_last, m_error);
    end
    n_cmp++;
    if ({m_data, frame_len} !== 24'd0) begin
      n_bad++;
      $display("FAIL reset_data_len: got data=%h len=%0d expected 0/0", m_data, frame_len);
    end
    n_cmp++;
    if ({stat_frames, stat_errors} !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_stats: got frames=%0d errors=%0d expected 0/0", stat_frames, stat_errors);
    end
    rst_n = 1'b1;
    step_idle();
  endtask

  task automatic test_good_frame();
    apply_reset();
    build(7, 64, 1'b1);
    run_burst(4);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL good_count: got %0d beats expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL good_beat[%0d]: got d=%h l=%b e=%b len=%0d cyc=%0d expected d=%h l=%b e=%b len=%0d cyc=%0d",
                 i, obs[i].data, obs[i].last, obs[i].error, obs[i].len, obs[i].cyc,
                 exp_q[i].data, exp_q[i].last, exp_q[i].error, exp_q[i].len, exp_q[i].cyc);
      end
    end
    n_cmp++;
    if (stat_frames !== 16'd1 || stat_errors !== 16'd0) begin
      n_bad++;
      $display("FAIL good_stats: got frames=%0d errors=%0d expected 1/0", stat_frames, stat_errors);
    end
  endtask

  task automatic test_rx_error();
    apply_reset();
    build(7, 64, 1'b1);
    burst[8 + 10].er = 1'b1;
    run_burst(4);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rxer_count: got %0d beats expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL rxer_beat[%0d]: got d=%h l=%b e=%b len=%0d expected d=%h l=%b e=%b len=%0d",
                 i, obs[i].data, obs[i].last, obs[i].error, obs[i].len,
                 exp_q[i].data, exp_q[i].last, exp_q[i].error, exp_q[i].len);
      end
    end
    n_cmp++;
    if (stat_frames !== 16'd1 || stat_errors !== 16'd1) begin
      n_bad++;
      $display("FAIL rxer_stats: got frames=%0d errors=%0d expected 1/1", stat_frames, stat_errors);
    end
  endtask

  // Length boundaries: runt, one short of minimum, maximum, one over maximum.
  task automatic test_runt_oversize();
    int lens[4] = '{20, 63, 1518, 1519};
    apply_reset();
    foreach (lens[k]) begin
      build(1, lens[k], 1'b0);
      run_burst(2);
    end
    step_idle();
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL len_count: got %0d beats expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      if (exp_q[i].last || obs[i].last) begin
        n_cmp++;
        if (obs[i] !== exp_q[i]) begin
          n_bad++;
          $display("FAIL len_last[%0d]: got l=%b e=%b len=%0d expected l=%b e=%b len=%0d",
                   i, obs[i].last, obs[i].error, obs[i].len, exp_q[i].last, exp_q[i].error, exp_q[i].len);
        end
      end
    end
    n_cmp++;
    if (stat_frames !== 16'(exp_frames) || stat_errors !== 16'(exp_errors)) begin
      n_bad++;
      $display("FAIL len_stats: got frames=%0d errors=%0d expected %0d/%0d",
               stat_frames, stat_errors, exp_frames, exp_errors);
    end
  endtask

  task automatic test_drop();
    apply_reset();
    build(0, 29, 1'b0);
    burst[0].b = 8'hAB;
    run_burst(3);
    n_cmp++;
    if (obs.size() != 0 || stat_errors !== 16'd1) begin
      n_bad++;
      $display("FAIL drop_bad_start: got beats=%0d errors=%0d expected 0/1", obs.size(), stat_errors);
    end
    build(1, 0, 1'b0);
    run_burst(3);
    n_cmp++;
    if (obs.size() != 0 || stat_errors !== 16'd2 || stat_frames !== 16'd0) begin
      n_bad++;
      $display("FAIL drop_empty: got beats=%0d errors=%0d frames=%0d expected 0/2/0",
               obs.size(), stat_errors, stat_frames);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    build($urandom_range(1, 7), $urandom_range(64, 80), 1'b0);
    run_burst(1);
    build($urandom_range(1, 7), $urandom_range(64, 80), 1'b0);
    run_burst(4);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d beats expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL b2b_beat[%0d]: got d=%h l=%b e=%b len=%0d cyc=%0d expected d=%h l=%b e=%b len=%0d cyc=%0d",
                 i, obs[i].data, obs[i].last, obs[i].error, obs[i].len, obs[i].cyc,
                 exp_q[i].data, exp_q[i].last, exp_q[i].error, exp_q[i].len, exp_q[i].cyc);
      end
    end
    n_cmp++;
    if (stat_frames !== 16'd2 || stat_errors !== 16'd0) begin
      n_bad++;
      $display("FAIL b2b_stats: got frames=%0d errors=%0d expected 2/0", stat_frames, stat_errors);
    end
  endtask

  // Reset pulse on payload byte 30: only bytes already emitted before the reset edge may appear.
  task automatic test_reset_midframe();
    int unsigned start;
    apply_reset();
    build(7, 64, 1'b0);
    start = cyc;
    for (int i = 0; i < 38; i++) step(1'b1, burst[i].er, burst[i].b);
    rst_n = 1'b0;
    step(1'b1, 1'b0, burst[38].b);
    rst_n = 1'b1;
    repeat (4) step_idle();
    for (int j = 8; j + 2 <= 38; j++)
      exp_q.push_back('{data: burst[j].b, last: 1'b0, error: 1'b0, len: 16'd0, cyc: start + 32'(j) + 2});
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rstmid_count: got %0d beats expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL rstmid_beat[%0d]: got d=%h l=%b cyc=%0d expected d=%h l=%b cyc=%0d",
                 i, obs[i].data, obs[i].last, obs[i].cyc, exp_q[i].data, exp_q[i].last, exp_q[i].cyc);
      end
    end
    n_cmp++;
    if (stat_frames !== 16'd0 || stat_errors !== 16'd0) begin
      n_bad++;
      $display("FAIL rstmid_stats: got frames=%0d errors=%0d expected 0/0", stat_frames, stat_errors);
    end
    obs.delete();
    exp_q.delete();
    exp_frames = 0;
    exp_errors = 0;
    build($urandom_range(1, 7), 64, 1'b0);
    run_burst(4);
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rstmid_next_count: got %0d beats expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL rstmid_next_beat[%0d]: got d=%h l=%b len=%0d expected d=%h l=%b len=%0d",
                 i, obs[i].data, obs[i].last, obs[i].len, exp_q[i].data, exp_q[i].last, exp_q[i].len);
      end
    end
    n_cmp++;
    if (stat_frames !== 16'd1 || stat_errors !== 16'd0) begin
      n_bad++;
      $display("FAIL rstmid_next_stats: got frames=%0d errors=%0d expected 1/0", stat_frames, stat_errors);
    end
  endtask

  task automatic test_random();
    int pre;
    int t;
    apply_reset();
    for (int f = 0; f < 24; f++) begin
      pre = $urandom_range(1, 7);
      t   = $urandom_range(0, 6);
      case (t)
        3: begin
          build(pre, $urandom_range(1, 40), 1'b0);
          burst[0].b = 8'($urandom);
          if (burst[0].b == 8'h55) burst[0].b = 8'hAB;
        end
        4: build(pre, 0, 1'b0);
        5: begin
          build(pre, $urandom_range(1, 40), 1'b0);
          burst[$urandom_range(0, pre)].er = 1'b1;
        end
        6: begin
          build(pre, 0, 1'b0);
          void'(burst.pop_back());
        end
        default: begin
          build(pre, $urandom_range(1, 100), 1'b0);
          if ($urandom_range(0, 3) == 0) burst[$urandom_range(pre + 1, burst.size() - 1)].er = 1'b1;
        end
      endcase
      run_burst($urandom_range(1, 3));
    end
    repeat (3) step_idle();
    n_cmp++;
    if (obs.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL rand_count: got %0d beats expected %0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL rand_beat[%0d]: got d=%h l=%b e=%b len=%0d cyc=%0d expected d=%h l=%b e=%b len=%0d cyc=%0d",
                 i, obs[i].data, obs[i].last, obs[i].error, obs[i].len, obs[i].cyc,
                 exp_q[i].data, exp_q[i].last, exp_q[i].error, exp_q[i].len, exp_q[i].cyc);
      end
    end
    n_cmp++;
    if (stat_frames !== 16'(exp_frames) || stat_errors !== 16'(exp_errors)) begin
      n_bad++;
      $display("FAIL rand_stats: got frames=%0d errors=%0d expected %0d/%0d",
               stat_frames, stat_errors, exp_frames, exp_errors);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    cyc        = 0;
    exp_frames = 0;
    exp_errors = 0;
    rst_n      = 1'b0;
    ddr_rise   = '0;
    ddr_fall   = '0;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_rx_error();
    test_runt_oversize();
    test_drop();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
